// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: drives a req/ack data-memory access for loads/stores,
// stalls upstream while it is outstanding, resolves branches and holds the MEM/WB register.
module mem_stage_ctrl #(
   parameter int XLEN    = 64,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] Adderout,
   input  logic            zero,
   input  logic [XLEN-1:0] result_alu,
   input  logic [XLEN-1:0] writedata,
   input  logic [4:0]      rd,
   input  logic            Branch,
   input  logic            Memread,
   input  logic            Memtoreg,
   input  logic            Memwrite,
   input  logic            Regwrite,
   input  logic            addermuxselect,
   input  logic            flush,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic [XLEN-1:0] dmem_rdata,
   input  logic            dmem_ack,
   output logic            stall,
   output logic            pcsrc,
   output logic [XLEN-1:0] branch_target,
   output logic            mem_err,
   output logic [XLEN-1:0] wb_readdata,
   output logic [XLEN-1:0] wb_alu_result,
   output logic [4:0]      wb_rd,
   output logic            wb_Memtoreg,
   output logic            wb_Regwrite,
   output logic [1:0]      dbg_state
);

   // Memory handshake: dmem_req rises registered and stays high, with address,
   // write-enable and write data frozen, until the edge that samples dmem_ack=1.
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt;
   logic              abort;
   logic [XLEN-1:0]   rdata_r;
   logic              memop, misaligned, start, ack_hit, tmo, wb_load, squash;

   assign memop      = Memread | Memwrite;
   assign misaligned = memop & (result_alu[2:0] != 3'd0);
   assign start      = (state == S_IDLE) & memop & ~misaligned;
   assign ack_hit    = (state == S_WAIT) & dmem_ack;
   assign tmo        = (state == S_WAIT) & ~dmem_ack & (cnt == CNT_W'(TIMEOUT - 1));
   assign wb_load    = ((state == S_IDLE) & ~start) | (state == S_DONE);
   assign squash     = ((state == S_IDLE) & misaligned) | ((state == S_DONE) & abort);

   // Stall is forced low while reset is held so the front end is released at once.
   assign stall         = reset & (start | (state == S_WAIT));
   assign pcsrc         = Branch & zero & ~stall;
   assign branch_target = addermuxselect ? {result_alu[XLEN-1:1], 1'b0} : Adderout;
   assign dbg_state     = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_WAIT;
         S_WAIT:  if (ack_hit || tmo) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         dmem_addr     <= '0;
         dmem_wdata    <= '0;
         cnt           <= '0;
         abort         <= 1'b0;
         rdata_r       <= '0;
         mem_err       <= 1'b0;
         wb_readdata   <= '0;
         wb_alu_result <= '0;
         wb_rd         <= '0;
         wb_Memtoreg   <= 1'b0;
         wb_Regwrite   <= 1'b0;
      end else begin
         mem_err <= tmo | ((state == S_IDLE) & misaligned);
         if (start) begin
            dmem_req   <= 1'b1;
            dmem_we    <= Memwrite;
            dmem_addr  <= result_alu;
            dmem_wdata <= writedata;
            cnt        <= '0;
            abort      <= 1'b0;
            rdata_r    <= '0;
         end else if (ack_hit) begin
            dmem_req <= 1'b0;
            if (!dmem_we) rdata_r <= dmem_rdata;
         end else if (tmo) begin
            dmem_req <= 1'b0;
            abort    <= 1'b1;
         end else if (state == S_WAIT) begin
            cnt <= cnt + CNT_W'(1);
         end

         if (wb_load) begin
            if (flush) begin
               wb_readdata   <= '0;
               wb_alu_result <= '0;
               wb_rd         <= '0;
               wb_Memtoreg   <= 1'b0;
               wb_Regwrite   <= 1'b0;
            end else begin
               wb_readdata   <= (state == S_DONE) ? rdata_r : '0;
               wb_alu_result <= result_alu;
               wb_rd         <= rd;
               wb_Memtoreg   <= Memtoreg;
               wb_Regwrite   <= Regwrite & ~squash;
            end
         end
      end
   end

endmodule
